// File: rtl/tri_vertex_sequencer.sv
// tri_vertex_sequencer
// Feeds triangles from the per-character triangle BRAM into the perspective
// projection stage (scale_vec) and packs the returned screen coordinates into
// one 2D triangle for the rasterizer.
//
// Ports:
//   clk_in, rst_in         clock, synchronous active-low reset
//   start_in               one-cycle pulse starting a pass (ignored while busy)
//   bram_addr_out          triangle BRAM read address
//   bram_data_in           {ax,ay,az,bx,by,bz,cx,cy,cz}, 32-bit floats, ax at MSB
//   vec_x/y/z_out          vertex to scale_vec, zero when vec_valid_out=0
//   vec_valid_out          vertex valid to scale_vec (no backpressure)
//   screen_x/y_in          projected coordinates, returned in issue order
//   screen_valid_in        projected result valid
//   tri_out                {ax,ay,bx,by,cx,cy}, 10 bits each, ax at MSB
//   tri_valid_out          triangle valid; tri_ready_in is the downstream ready
//   busy_out, done_out     busy outside IDLE / one-cycle end-of-pass pulse
//   drop_count_out         triangles dropped by timeout this pass, saturating
//   state_out              current FSM state (debug)
//
// Handshake: a triangle transfers on a cycle where tri_valid_out and
// tri_ready_in are both 1; tri_out is held stable while tri_valid_out=1 and
// tri_ready_in=0, and tri_valid_out never drops before the transfer.
module tri_vertex_sequencer #(
   parameter int TRI_COUNT    = 64,
   parameter int ADDR_W       = 6,
   parameter int BRAM_LATENCY = 2,
   parameter int TIMEOUT      = 64
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              start_in,
   output logic [ADDR_W-1:0] bram_addr_out,
   input  logic [287:0]      bram_data_in,
   output logic [31:0]       vec_x_out,
   output logic [31:0]       vec_y_out,
   output logic [31:0]       vec_z_out,
   output logic              vec_valid_out,
   input  logic [9:0]        screen_x_in,
   input  logic [9:0]        screen_y_in,
   input  logic              screen_valid_in,
   output logic [59:0]       tri_out,
   output logic              tri_valid_out,
   input  logic              tri_ready_in,
   output logic              busy_out,
   output logic              done_out,
   output logic [7:0]        drop_count_out,
   output logic [2:0]        state_out
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] FETCH   = 3'd1;
   localparam logic [2:0] ISSUE   = 3'd2;
   localparam logic [2:0] COLLECT = 3'd3;
   localparam logic [2:0] DRAIN   = 3'd4;
   localparam logic [2:0] OUTPUT  = 3'd5;
   localparam logic [2:0] ADVANCE = 3'd6;

   // One counter serves the fetch wait, the issue-to-result timeout and the
   // drain window, so it is sized for the largest of them.
   localparam int CMAX = (TIMEOUT > BRAM_LATENCY) ? TIMEOUT : BRAM_LATENCY;
   localparam int CW   = $clog2(CMAX + 1);

   logic [2:0]    state;
   logic [CW-1:0] cnt;
   logic [1:0]    issue_idx;
   logic [1:0]    res_idx;
   logic [287:0]  vtx;
   logic [19:0]   slot_a, slot_b, slot_c;
   logic          accept;
   logic          third;
   logic          last_tri;

   // Results only count while a triangle is actually in flight.
   assign accept   = screen_valid_in && ((state == ISSUE) || (state == COLLECT));
   assign third    = accept && (res_idx == 2'd2);
   assign last_tri = (bram_addr_out == ADDR_W'(TRI_COUNT - 1));

   assign state_out     = state;
   assign busy_out      = (state != IDLE);
   assign done_out      = (state == ADVANCE) && last_tri;
   assign tri_valid_out = (state == OUTPUT);
   assign tri_out       = (state == OUTPUT) ? {slot_a, slot_b, slot_c} : 60'd0;
   assign vec_valid_out = (state == ISSUE);

   always_comb begin
      vec_x_out = 32'd0;
      vec_y_out = 32'd0;
      vec_z_out = 32'd0;
      if (state == ISSUE) begin
         case (issue_idx)
            2'd0:    {vec_x_out, vec_y_out, vec_z_out} = vtx[287:192];
            2'd1:    {vec_x_out, vec_y_out, vec_z_out} = vtx[191:96];
            default: {vec_x_out, vec_y_out, vec_z_out} = vtx[95:0];
         endcase
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state          <= IDLE;
         bram_addr_out  <= '0;
         drop_count_out <= 8'd0;
         cnt            <= '0;
         issue_idx      <= 2'd0;
         res_idx        <= 2'd0;
         vtx            <= 288'd0;
         slot_a         <= 20'd0;
         slot_b         <= 20'd0;
         slot_c         <= 20'd0;
      end else begin
         if (accept) begin
            case (res_idx)
               2'd0:    slot_a <= {screen_x_in, screen_y_in};
               2'd1:    slot_b <= {screen_x_in, screen_y_in};
               default: slot_c <= {screen_x_in, screen_y_in};
            endcase
            if (res_idx != 2'd2) res_idx <= res_idx + 2'd1;
         end

         case (state)
            IDLE: begin
               if (start_in) begin
                  bram_addr_out  <= '0;
                  drop_count_out <= 8'd0;
                  cnt            <= '0;
                  state          <= FETCH;
               end
            end
            FETCH: begin
               if (cnt == CW'(BRAM_LATENCY - 1)) begin
                  vtx       <= bram_data_in;
                  cnt       <= '0;     // first ISSUE cycle sees timeout count 0
                  issue_idx <= 2'd0;
                  res_idx   <= 2'd0;
                  state     <= ISSUE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ISSUE: begin
               cnt       <= cnt + 1'b1;
               issue_idx <= issue_idx + 2'd1;
               if (third)                   state <= OUTPUT;
               else if (issue_idx == 2'd2)  state <= COLLECT;
            end
            COLLECT: begin
               if (third) begin
                  state <= OUTPUT;
               end else if (cnt == CW'(TIMEOUT - 1)) begin
                  if (drop_count_out != 8'hFF) drop_count_out <= drop_count_out + 8'd1;
                  cnt   <= '0;
                  state <= DRAIN;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DRAIN: begin
               // Late results from the dropped triangle must not reach the
               // next one, so wait out a full timeout window.
               if (cnt == CW'(TIMEOUT - 1)) state <= ADVANCE;
               else                         cnt   <= cnt + 1'b1;
            end
            OUTPUT: begin
               if (tri_ready_in) state <= ADVANCE;
            end
            ADVANCE: begin
               if (last_tri) begin
                  state <= IDLE;
               end else begin
                  bram_addr_out <= bram_addr_out + 1'b1;
                  cnt           <= '0;
                  state         <= FETCH;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tri_vertex_sequencer.sv
// Testbench for tri_vertex_sequencer: a 4-triangle instance driven through
// full passes against a 5-cycle echo model of scale_vec, plus a 300-triangle
// instance with no scale_vec responses to saturate the drop counter.
module tb_tri_vertex_sequencer;

   localparam int        N_TRI    = 4;
   localparam logic [2:0] ST_DRAIN = 3'd4;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst = 1'b0;
   logic         start = 1'b0;
   logic [1:0]   bram_addr;
   logic [287:0] bram_q;
   logic [31:0]  vec_x, vec_y, vec_z;
   logic         vec_valid;
   logic [9:0]   screen_x, screen_y;
   logic         screen_valid;
   logic [59:0]  tri_o;
   logic         tri_valid;
   logic         tri_ready = 1'b1;
   logic         busy, done;
   logic [7:0]   drop;
   logic [2:0]   state;

   logic         rst2 = 1'b0;
   logic         start2 = 1'b0;
   logic [8:0]   bram_addr2;
   logic [31:0]  vec_x2, vec_y2, vec_z2;
   logic         vec_valid2;
   logic [59:0]  tri_o2;
   logic         tri_valid2, busy2, done2;
   logic [7:0]   drop2;
   logic [2:0]   state2;

   tri_vertex_sequencer #(.TRI_COUNT(N_TRI), .ADDR_W(2), .BRAM_LATENCY(2), .TIMEOUT(64)) dut (
      .clk_in(clk), .rst_in(rst), .start_in(start),
      .bram_addr_out(bram_addr), .bram_data_in(bram_q),
      .vec_x_out(vec_x), .vec_y_out(vec_y), .vec_z_out(vec_z), .vec_valid_out(vec_valid),
      .screen_x_in(screen_x), .screen_y_in(screen_y), .screen_valid_in(screen_valid),
      .tri_out(tri_o), .tri_valid_out(tri_valid), .tri_ready_in(tri_ready),
      .busy_out(busy), .done_out(done), .drop_count_out(drop), .state_out(state)
   );

   tri_vertex_sequencer #(.TRI_COUNT(300), .ADDR_W(9), .BRAM_LATENCY(2), .TIMEOUT(8)) dut2 (
      .clk_in(clk), .rst_in(rst2), .start_in(start2),
      .bram_addr_out(bram_addr2), .bram_data_in(288'd0),
      .vec_x_out(vec_x2), .vec_y_out(vec_y2), .vec_z_out(vec_z2), .vec_valid_out(vec_valid2),
      .screen_x_in(10'd0), .screen_y_in(10'd0), .screen_valid_in(1'b0),
      .tri_out(tri_o2), .tri_valid_out(tri_valid2), .tri_ready_in(1'b1),
      .busy_out(busy2), .done_out(done2), .drop_count_out(drop2), .state_out(state2)
   );

   // ---------------- vector table ----------------
   typedef struct {
      logic [9:0]  ax, ay, bx, by, cx, cy;
      logic [59:0] exp;
   } vec_t;
   vec_t         tab[N_TRI];
   logic [287:0] mem[N_TRI];

   function automatic logic [287:0] make_word(input vec_t t);
      logic [31:0] z;
      z = 32'h4040_0000;
      return {32'h3f80_0000 | {22'd0, t.ax}, 32'h4000_0000 | {22'd0, t.ay}, z,
              32'h3f80_0000 | {22'd0, t.bx}, 32'h4000_0000 | {22'd0, t.by}, z,
              32'h3f80_0000 | {22'd0, t.cx}, 32'h4000_0000 | {22'd0, t.cy}, z};
   endfunction

   // BRAM model: one registered stage, so data is valid by the last FETCH cycle.
   always @(posedge clk) bram_q <= mem[bram_addr];

   // ---------------- scale_vec echo model (5-cycle latency) ----------------
   logic [4:0]       pipe_v;
   logic [4:0][9:0]  pipe_x, pipe_y;
   logic [1:0]       phase;
   logic             suppress_en = 1'b0;
   logic [1:0]       suppress_addr = 2'd0;
   logic             inj_v = 1'b0;
   logic [9:0]       inj_x = 10'd0, inj_y = 10'd0;

   always @(posedge clk) begin
      if (!rst) begin
         pipe_v <= '0;
         pipe_x <= '0;
         pipe_y <= '0;
         phase  <= 2'd0;
      end else begin
         pipe_v <= {pipe_v[3:0],
                    vec_valid && !(suppress_en && bram_addr == suppress_addr && phase == 2'd1)};
         pipe_x <= {pipe_x[3:0], vec_x[9:0]};
         pipe_y <= {pipe_y[3:0], vec_y[9:0]};
         phase  <= vec_valid ? phase + 2'd1 : 2'd0;
      end
   end

   assign screen_valid = pipe_v[4] | inj_v;
   assign screen_x     = inj_v ? inj_x : pipe_x[4];
   assign screen_y     = inj_v ? inj_y : pipe_y[4];

   // ---------------- monitor ----------------
   logic [59:0] got_q[$];
   int hs_cnt = 0, done_cnt = 0, vec_bad = 0, tv2_cnt = 0;

   always @(negedge clk) begin
      if (tri_valid && tri_ready) begin
         got_q.push_back(tri_o);
         hs_cnt++;
      end
      if (done) done_cnt++;
      if (!vec_valid && ((vec_x | vec_y | vec_z) != 32'd0)) vec_bad++;
      if (!vec_valid2 && ((vec_x2 | vec_y2 | vec_z2) != 32'd0)) vec_bad++;
      if (tri_valid2) tv2_cnt++;
   end

   // ---------------- scoreboard / checks ----------------
   logic [59:0] exp_q[$];
   int errors = 0, checks = 0;
   int base = 0, done0 = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic begin_pass(input int skip);
      base  = got_q.size();
      done0 = done_cnt;
      for (int i = 0; i < N_TRI; i++)
         if (i != skip) exp_q.push_back(tab[i].exp);
      pulse_start();
   endtask

   task automatic finish_pass(input string name, input int n_exp);
      int n;
      n = 0;
      while (!done && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_done_seen"}, 64'(done), 64'd1);
      repeat (2) @(negedge clk);
      chk({name, "_handshakes"}, 64'(got_q.size() - base), 64'(n_exp));
      for (int i = 0; i < n_exp && (base + i) < got_q.size() && exp_q.size() > 0; i++)
         chk({name, "_tri"}, 64'(got_q[base + i]), 64'(exp_q.pop_front()));
      chk({name, "_done_pulses"}, 64'(done_cnt - done0), 64'd1);
      chk({name, "_busy_low"}, 64'(busy), 64'd0);
      exp_q.delete();
   endtask

   // ---------------- test sequence ----------------
   logic [59:0] held_tri;
   logic [1:0]  held_addr;
   int          n, h0;

   initial begin
      tab[0] = '{ax: 10'd1,    ay: 10'd2,    bx: 10'd3,   by: 10'd4,    cx: 10'd5,   cy: 10'd6,
                 exp: {10'd1, 10'd2, 10'd3, 10'd4, 10'd5, 10'd6}};
      tab[1] = '{ax: 10'd1023, ay: 10'd0,    bx: 10'd512, by: 10'd511,  cx: 10'd7,   cy: 10'd1000,
                 exp: {10'd1023, 10'd0, 10'd512, 10'd511, 10'd7, 10'd1000}};
      tab[2] = '{ax: 10'd100,  ay: 10'd200,  bx: 10'd300, by: 10'd400,  cx: 10'd500, cy: 10'd600,
                 exp: {10'd100, 10'd200, 10'd300, 10'd400, 10'd500, 10'd600}};
      tab[3] = '{ax: 10'd0,    ay: 10'd1023, bx: 10'd1,   by: 10'd1022, cx: 10'd2,   cy: 10'd1021,
                 exp: {10'd0, 10'd1023, 10'd1, 10'd1022, 10'd2, 10'd1021}};
      for (int i = 0; i < N_TRI; i++) mem[i] = make_word(tab[i]);

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_tri_valid", 64'(tri_valid), 64'd0);
      chk("rst_tri_out", 64'(tri_o), 64'd0);
      chk("rst_vec_valid", 64'(vec_valid), 64'd0);
      chk("rst_addr", 64'(bram_addr), 64'd0);
      chk("rst_drop", 64'(drop), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_state", 64'(state), 64'd0);
      rst = 1'b1;
      rst2 = 1'b1;
      repeat (2) @(negedge clk);

      // 1: plain pass over all triangles
      begin_pass(-1);
      finish_pass("pass1", N_TRI);
      chk("pass1_drop", 64'(drop), 64'd0);

      // 2: downstream stall on the first triangle
      tri_ready = 1'b0;
      begin_pass(-1);
      n = 0;
      while (!tri_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("stall_valid_seen", 64'(tri_valid), 64'd1);
      held_tri  = tri_o;
      held_addr = bram_addr;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("stall_valid_held", 64'(tri_valid), 64'd1);
         chk("stall_tri_held", 64'(tri_o), 64'(held_tri));
         chk("stall_addr_held", 64'(bram_addr), 64'(held_addr));
      end
      tri_ready = 1'b1;
      finish_pass("stall", N_TRI);

      // 3: vertex B of triangle 1 never returns; a stray result arrives in DRAIN
      suppress_en   = 1'b1;
      suppress_addr = 2'd1;
      begin_pass(1);
      n = 0;
      while (state != ST_DRAIN && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("drop_reached_drain", 64'(state), 64'(ST_DRAIN));
      chk("drop_count_mid", 64'(drop), 64'd1);
      repeat (3) @(negedge clk);
      inj_x = 10'd999;
      inj_y = 10'd888;
      inj_v = 1'b1;
      @(negedge clk);
      inj_v = 1'b0;
      finish_pass("drop", N_TRI - 1);
      chk("drop_count_end", 64'(drop), 64'd1);
      suppress_en = 1'b0;

      // 4: start pulsed mid-pass is ignored
      begin_pass(-1);
      h0 = hs_cnt;
      n = 0;
      while (hs_cnt == h0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      pulse_start();
      finish_pass("midstart", N_TRI);
      chk("midstart_drop_cleared", 64'(drop), 64'd0);
      repeat (5) @(negedge clk);
      chk("midstart_not_queued", 64'(busy), 64'd0);

      // 5: reset during COLLECT after one result
      begin_pass(-1);
      n = 0;
      while (!screen_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("collect_first_result", 64'(screen_valid), 64'd1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_state", 64'(state), 64'd0);
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_vec", 64'({vec_valid, vec_x, vec_y[9:0]}), 64'd0);
      chk("midrst_tri", 64'({tri_valid, tri_o}), 64'd0);
      chk("midrst_addr_drop", 64'({bram_addr, drop, done}), 64'd0);
      exp_q.delete();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      begin_pass(-1);
      finish_pass("after_rst", N_TRI);

      // 6: 300 forced timeouts saturate the drop counter
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      n = 0;
      while (!done2 && n < 20000) begin
         @(negedge clk);
         n++;
      end
      chk("sat_done_seen", 64'(done2), 64'd1);
      chk("sat_drop_count", 64'(drop2), 64'd255);
      chk("sat_no_triangles", 64'(tv2_cnt), 64'd0);
      @(negedge clk);
      chk("sat_busy_low", 64'(busy2), 64'd0);

      chk("vec_zero_when_idle", 64'(vec_bad), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
